// File: rtl/mac_pkg.sv
// Shared types for the MAC operand streamer: operand/accumulator widths,
// controller state encoding and the buffered operand-pair layout.
package mac_pkg;

  localparam int W     = 14;
  localparam int ACC_W = 28;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    ISSUE = 2'd2,
    DRAIN = 2'd3
  } mac_state_e;

  typedef struct packed {
    logic signed [W-1:0] a;
    logic signed [W-1:0] b;
  } mac_pair_t;

endpackage

// File: rtl/mac_operand_streamer_operand_buf.sv
// Operand-pair register file: one synchronous write port, one combinational
// read port. Contents are deliberately not reset.
module operand_buf
  import mac_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  mac_pair_t       wdata,
  input  logic [AW-1:0]   raddr,
  output mac_pair_t       rdata
);

  mac_pair_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mac_operand_streamer.sv
// Streams one buffered vector of operand pairs into a saturating MAC after
// clearing it, counts the MAC's valid_out pulses and captures the final sum.
module mac_operand_streamer #(
  parameter int W     = mac_pkg::W,
  parameter int ACC_W = mac_pkg::ACC_W,
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [W-1:0]        wr_a,
  input  logic [W-1:0]        wr_b,
  input  logic                start,
  input  logic [AW:0]         len,
  input  logic                hold,
  output logic                busy,
  output logic                done,
  output logic [ACC_W-1:0]    result,
  output logic                mac_clr,
  output logic                mac_valid_in,
  output logic [W-1:0]        mac_a,
  output logic [W-1:0]        mac_b,
  input  logic [ACC_W-1:0]    mac_f,
  input  logic                mac_valid_out,
  output mac_pkg::mac_state_e state_dbg
);

  import mac_pkg::*;

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE = (AW+1)'(1);

  mac_state_e  state;
  logic [AW:0] len_r;
  logic [AW:0] issue_cnt;
  logic [AW:0] rcv_cnt;

  logic [AW:0] len_clamped;
  logic        issue_go;
  logic        last_rcv;
  logic        buf_we;
  mac_pair_t   wr_pair;
  mac_pair_t   rd_pair;

  // Handshake: mac_valid_in qualifies mac_a/mac_b for exactly the cycle it is
  // high; there is no ready from the MAC, hold=1 is the only back-pressure and
  // simply withholds the next pair. mac_valid_out is a one-cycle pulse per pair.
  always_comb begin
    len_clamped = (len > DEPTH_L) ? DEPTH_L : len;
    issue_go    = !hold && (((state == CLEAR) && (len_r != '0)) ||
                            ((state == ISSUE) && (issue_cnt != len_r)));
    last_rcv    = mac_valid_out && ((state == ISSUE) || (state == DRAIN)) &&
                  (rcv_cnt == (len_r - CNT_ONE));
    buf_we      = wr_en && (state == IDLE);
    wr_pair.a   = $signed(wr_a);
    wr_pair.b   = $signed(wr_b);
  end

  operand_buf #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (wr_addr),
    .wdata (wr_pair),
    .raddr (issue_cnt[AW-1:0]),
    .rdata (rd_pair)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      result       <= '0;
      mac_clr      <= 1'b0;
      mac_valid_in <= 1'b0;
      mac_a        <= '0;
      mac_b        <= '0;
      len_r        <= '0;
      issue_cnt    <= '0;
      rcv_cnt      <= '0;
    end else begin
      done <= 1'b0;

      // The first pair already leaves on the CLEAR->ISSUE edge, so the MAC
      // sees its clear and the first operand on consecutive edges.
      if (issue_go) begin
        mac_valid_in <= 1'b1;
        mac_a        <= rd_pair.a;
        mac_b        <= rd_pair.b;
        issue_cnt    <= issue_cnt + CNT_ONE;
      end else begin
        mac_valid_in <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (start) begin
            len_r     <= len_clamped;
            busy      <= 1'b1;
            mac_clr   <= 1'b1;
            issue_cnt <= '0;
            rcv_cnt   <= '0;
            state     <= CLEAR;
          end
        end
        CLEAR: begin
          mac_clr <= 1'b0;
          if (len_r == '0) begin
            done   <= 1'b1;
            result <= '0;
            busy   <= 1'b0;
            state  <= IDLE;
          end else begin
            state <= ISSUE;
          end
        end
        ISSUE: begin
          if (issue_cnt == len_r) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
        end
        default: state <= IDLE;
      endcase

      // Receive counting spans ISSUE and DRAIN so any MAC latency >= 1 works.
      if (mac_valid_out && ((state == ISSUE) || (state == DRAIN))) begin
        rcv_cnt <= rcv_cnt + CNT_ONE;
      end
      if (last_rcv) begin
        result       <= mac_f;
        done         <= 1'b1;
        busy         <= 1'b0;
        mac_valid_in <= 1'b0;
        state        <= IDLE;
      end
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_mac_operand_streamer.sv
// Bench for mac_operand_streamer: a behavioural saturating MAC closes the loop,
// a scoreboard queues expected pairs and dot products, a monitor checks them.
module tb_mac_operand_streamer;
  import mac_pkg::*;

  localparam int DEPTH = 64;
  localparam int AW    = $clog2(DEPTH);
  localparam longint ACC_MAX = (longint'(1) <<< (ACC_W-1)) - 1;
  localparam longint ACC_MIN = -(longint'(1) <<< (ACC_W-1));

  logic clk = 1'b0;
  logic reset, wr_en, start, hold, spur;
  logic [AW-1:0] wr_addr;
  logic [W-1:0] wr_a, wr_b;
  logic [AW:0] len;
  logic busy, done, mac_clr, mac_valid_in, mac_valid_out;
  logic [ACC_W-1:0] result, mac_f;
  logic [W-1:0] mac_a, mac_b;
  mac_state_e state_dbg;

  logic signed [ACC_W-1:0] mac_acc;
  logic mac_vout_m;

  int sh_a[DEPTH];
  int sh_b[DEPTH];
  logic [ACC_W-1:0] exp_q[$];
  logic [2*W-1:0] exp_pair_q[$];
  int checks = 0, errors = 0, n_issue = 0, n_done = 0;

  // ---------------- clock / reset / watchdog
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  mac_operand_streamer #(.W(W), .ACC_W(ACC_W), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_a(wr_a),
    .wr_b(wr_b), .start(start), .len(len), .hold(hold), .busy(busy),
    .done(done), .result(result), .mac_clr(mac_clr), .mac_valid_in(mac_valid_in),
    .mac_a(mac_a), .mac_b(mac_b), .mac_f(mac_f), .mac_valid_out(mac_valid_out),
    .state_dbg(state_dbg)
  );

  function automatic longint sat(longint v);
    if (v > ACC_MAX) return ACC_MAX;
    if (v < ACC_MIN) return ACC_MIN;
    return v;
  endfunction

  // Saturating MAC, latency 1, reset by reset | mac_clr.
  always @(posedge clk) begin
    if (reset || mac_clr) begin
      mac_acc    <= '0;
      mac_vout_m <= 1'b0;
    end else begin
      mac_vout_m <= mac_valid_in;
      if (mac_valid_in)
        mac_acc <= ACC_W'(sat(longint'(mac_acc) +
                              longint'($signed(mac_a)) * longint'($signed(mac_b))));
    end
  end
  assign mac_f = mac_acc;
  assign mac_valid_out = mac_vout_m | spur;

  // Reference: saturating dot product over the first n shadow entries.
  function automatic logic [ACC_W-1:0] ref_dot(int n);
    longint acc;
    acc = 0;
    for (int i = 0; i < n; i++) acc = sat(acc + longint'(sh_a[i]) * longint'(sh_b[i]));
    return ACC_W'(acc);
  endfunction

  function automatic int rv();
    return int'($urandom_range(0, 16383)) - 8192;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- monitor / scoreboard
  always @(negedge clk) begin
    if (!reset) begin
      if (mac_valid_in) begin
        n_issue++;
        if (exp_pair_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL pair_unexpected actual=%h required=none", {mac_a, mac_b});
        end else check("pair", {mac_a, mac_b}, exp_pair_q.pop_front());
      end
      if (done) begin
        n_done++;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL done_unexpected actual=%h required=none", result);
        end else check("result", result, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks
  task automatic write_pair(int addr, int a, int b);
    logic [31:0] ua, ub, uad;
    ua = a; ub = b; uad = addr;
    @(negedge clk);
    wr_en = 1'b1; wr_addr = uad[AW-1:0]; wr_a = ua[W-1:0]; wr_b = ub[W-1:0];
    sh_a[addr] = a; sh_b[addr] = b;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic check_cleared(string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_result"}, result, 0);
    check({tag, "_mac_clr"}, mac_clr, 0);
    check({tag, "_valid_in"}, mac_valid_in, 0);
    check({tag, "_mac_a"}, mac_a, 0);
    check({tag, "_mac_b"}, mac_b, 0);
    check({tag, "_state"}, state_dbg, IDLE);
  endtask

  // mode: 0 free-running, 1 two-edge hold after first pair, 2 random hold,
  // 3 start/wr_en hammered while busy, 4 reset after two pairs issued.
  task automatic run(int ln, int mode);
    int n, seen, hold_left, exp_lat, done0;
    bit got, hold_done, aborted;
    logic [31:0] ul;
    n = (ln > DEPTH) ? DEPTH : ln;
    exp_lat = (n == 0) ? 1 : n + 2 + ((mode == 1) ? 2 : 0);
    for (int i = 0; i < n; i++) begin
      logic [31:0] ta, tb;
      ta = sh_a[i]; tb = sh_b[i];
      exp_pair_q.push_back({ta[W-1:0], tb[W-1:0]});
    end
    exp_q.push_back(ref_dot(n));
    done0 = n_done; seen = 0; hold_left = 0; got = 0; hold_done = 0; aborted = 0;
    ul = ln;
    @(negedge clk);
    start = 1'b1; len = ul[AW:0]; hold = 1'b0;
    @(negedge clk);
    check("clr_pulse", mac_clr, 1);
    check("busy_set", busy, 1);
    check("state_clear", state_dbg, CLEAR);
    start = (mode == 3);
    for (int c = 1; c <= 400 && !got && !aborted; c++) begin
      @(negedge clk);
      seen += int'(mac_valid_in);
      if (done) begin
        got = 1; start = 1'b0; hold = 1'b0; wr_en = 1'b0;
        if (mode != 2) check("latency", c, exp_lat);
      end else if (mode == 4 && seen == 2) begin
        reset = 1'b1; aborted = 1;
      end else begin
        if (mode == 1 && seen == 1 && !hold_done) begin hold_left = 2; hold_done = 1; end
        if (mode == 2) hold = ($urandom_range(0, 2) == 0);
        else begin
          hold = (hold_left > 0);
          if (hold_left > 0) hold_left--;
        end
        if (mode == 3) begin
          wr_en = 1'b1; wr_addr = AW'($urandom_range(0, 4));
          wr_a = W'($urandom); wr_b = W'($urandom);
        end
      end
    end
    if (mode == 4) begin
      check("abort_point", aborted, 1);
      @(negedge clk);
      reset = 1'b0;
      exp_q.delete(); exp_pair_q.delete();
      check_cleared("mid_reset");
      repeat (8) @(negedge clk);
      check("no_done_after_reset", n_done - done0, 0);
    end else begin
      check("done_seen", got, 1);
      if (!got) begin
        exp_q.delete(); exp_pair_q.delete();
        start = 1'b0; hold = 1'b0; wr_en = 1'b0;
      end
      check("issue_count", seen, n);
      @(negedge clk);
      check("done_single", done, 0);
      check("busy_clear", busy, 0);
      check("state_idle", state_dbg, IDLE);
      check("done_count", n_done - done0, 1);
    end
  endtask

  // ---------------- stimulus
  initial begin
    int d0;
    reset = 1'b1; wr_en = 1'b0; start = 1'b0; hold = 1'b0; spur = 1'b0;
    wr_addr = '0; wr_a = '0; wr_b = '0; len = '0;
    repeat (3) @(negedge clk);
    check_cleared("reset");
    reset = 1'b0;

    for (int i = 0; i < DEPTH; i++) write_pair(i, rv(), rv());

    // basic and hold
    write_pair(0, 1, 2); write_pair(1, 3, 4); write_pair(2, 5, 6);
    run(3, 0);
    check("basic_result", result, 28'h000002C);
    run(3, 1);
    check("hold_result", result, 28'h000002C);

    // saturation, then back-to-back accumulator clear
    for (int i = 0; i < 3; i++) write_pair(i, 8191, 8191);
    run(3, 0);
    check("sat_result", result, 28'h7FFFFFF);
    write_pair(0, 2, 3); write_pair(1, 0, 0); write_pair(2, 0, 0);
    run(3, 0);
    check("clr_result", result, 28'h0000006);

    // length boundaries
    run(0, 0);
    check("len0_result", result, 0);
    run(DEPTH + 5, 0);

    // spurious valid_out while idle
    d0 = n_done;
    @(negedge clk); spur = 1'b1;
    repeat (3) @(negedge clk);
    spur = 1'b0;
    @(negedge clk);
    check("spur_busy", busy, 0);
    check("spur_done_count", n_done - d0, 0);
    check("spur_state", state_dbg, IDLE);

    // start/wr_en while busy, then re-read the buffer
    for (int i = 0; i < 5; i++) write_pair(i, rv(), rv());
    run(5, 3);
    run(5, 0);

    // reset mid-issue then recovery
    write_pair(0, 1, 2); write_pair(1, 3, 4); write_pair(2, 5, 6);
    run(3, 4);
    run(3, 0);
    check("post_reset_result", result, 28'h000002C);

    // randomized vectors
    for (int r = 0; r < 12; r++) begin
      int ln, md;
      ln = $urandom_range(1, 24);
      if (r == 5) ln = DEPTH;
      for (int i = 0; i < ln; i++) write_pair(i, rv(), rv());
      md = ($urandom_range(0, 1) == 0) ? 0 : 2;
      run(ln, md);
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
